lut_neuron_sched: RTL and testbench

LUT_NEURON_SCHED -- requirements
Module: lut_neuron_sched

---
 rtl/lut_sched_pkg.sv | 50 +++++
 rtl/lut_neuron_sched_gather.sv | 24 ++
 rtl/lut_neuron_sched.sv | 140 ++++++++++++++
 tb/tb_lut_neuron_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_sched_pkg.sv
// Shared types and reset constants for the LUT neuron scheduler.
//   state_t       : scheduler FSM states
//   TT_INIT       : 64 neurons x 64-bit truth tables, neuron n at [n*64 +: 64]
//   CONN_INIT     : 64 neurons x 6 fields x 6 bits, neuron n field j at
//                   [n*36 + j*6 +: 6], value (n+j) mod 64; the scheduler keeps
//                   the low clog2(IN_W) bits, i.e. (n+j) mod IN_W
//   conn_sel_w()  : width of one connectivity field for a given IN_W
package lut_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int MAX_NEURONS  = 64;
  localparam int TT_BITS      = 64;
  localparam int CONN_FIELD   = 6;
  localparam int CONN_STRIDE  = 36;

  // Even neurons pass idx bit 0 through, odd neurons output the parity of
  // all six gathered inputs so every connectivity field matters at reset.
  localparam logic [63:0] TT_IDENT  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] TT_PARITY = 64'h6996_9669_9669_6996;

  function automatic int conn_sel_w(input int in_w);
    return $clog2(in_w);
  endfunction

  function automatic logic [MAX_NEURONS*TT_BITS-1:0] build_tt();
    logic [MAX_NEURONS*TT_BITS-1:0] t;
    t = '0;
    for (int n = 0; n < MAX_NEURONS; n++)
      t[n*TT_BITS +: TT_BITS] = (n % 2 == 1) ? TT_PARITY : TT_IDENT;
    return t;
  endfunction

  function automatic logic [MAX_NEURONS*CONN_STRIDE-1:0] build_conn();
    logic [MAX_NEURONS*CONN_STRIDE-1:0] c;
    c = '0;
    for (int n = 0; n < MAX_NEURONS; n++)
      for (int j = 0; j < 6; j++)
        c[n*CONN_STRIDE + j*CONN_FIELD +: CONN_FIELD] = 6'((n + j) % 64);
    return c;
  endfunction

  localparam logic [MAX_NEURONS*TT_BITS-1:0]     TT_INIT   = build_tt();
  localparam logic [MAX_NEURONS*CONN_STRIDE-1:0] CONN_INIT = build_conn();

endpackage

// File: rtl/lut_neuron_sched_gather.sv
// lut_fanin_gather: picks FANIN bits out of the captured input vector using
// one neuron's connectivity word and packs them into the LUT index.
//   vec  : captured input vector (IN_W)
//   conn : FANIN select fields of clog2(IN_W) bits, field j at [j*SEL_W +: SEL_W]
//   idx  : LUT index, bit j = vec[field j] (field 0 is the LSB)
// A select field is clog2(IN_W) bits wide, so selects wrap modulo IN_W.
module lut_fanin_gather
  import lut_sched_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int FANIN = 6
) (
  input  logic [IN_W-1:0]                     vec,
  input  logic [FANIN*conn_sel_w(IN_W)-1:0]   conn,
  output logic [FANIN-1:0]                    idx
);
  localparam int SEL_W = conn_sel_w(IN_W);

  always_comb begin
    idx = '0;
    for (int j = 0; j < FANIN; j++)
      idx[j] = vec[conn[j*SEL_W +: SEL_W]];
  end
endmodule

// File: rtl/lut_neuron_sched.sv
// lut_neuron_sched: evaluates NUM_NEURONS LUT neurons on one input vector by
// time-multiplexing a single FANIN-input lookup, one neuron per cycle.
//   clk, rst_n                 : clock, async active-low reset
//   s_valid/s_ready/s_data     : input vector handshake
//   m_valid/m_ready/m_data     : result handshake, bit k is neuron k
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata : table (sel=0) / connectivity (sel=1) write
//   busy                       : FSM not in IDLE
//   cfg_err                    : one-cycle pulse after a rejected write
// Build option: define LUT_SCHED_CFG_EN for writable tables/connectivity;
// otherwise they are the constants TT_INIT / CONN_INIT and cfg_* is ignored.
//
// state   | meaning
// IDLE    | ready for a vector
// EVAL    | evaluating neuron k, one per cycle
// OUT     | result held until m_ready
module lut_neuron_sched
  import lut_sched_pkg::*;
#(
  parameter int IN_W        = 32,
  parameter int NUM_NEURONS = 32,
  parameter int FANIN       = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [IN_W-1:0]                s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_NEURONS-1:0]         m_data,
  input  logic                           cfg_we,
  input  logic                           cfg_sel,
  input  logic [$clog2(NUM_NEURONS)-1:0] cfg_addr,
  input  logic [63:0]                    cfg_wdata,
  output logic                           busy,
  output logic                           cfg_err
);
  localparam int ADDR_W = $clog2(NUM_NEURONS);
  localparam int SEL_W  = conn_sel_w(IN_W);
  localparam int CONN_W = FANIN * SEL_W;
  localparam int TT_W   = 1 << FANIN;

  function automatic logic [CONN_W-1:0] conn_reset(input int n);
    logic [CONN_W-1:0] w;
    w = '0;
    for (int j = 0; j < FANIN; j++)
      w[j*SEL_W +: SEL_W] = CONN_INIT[n*CONN_STRIDE + j*CONN_FIELD +: SEL_W];
    return w;
  endfunction

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k;
  logic [IN_W-1:0]   in_q;
  logic [TT_W-1:0]   tt   [NUM_NEURONS];
  logic [CONN_W-1:0] conn [NUM_NEURONS];
  logic [FANIN-1:0]  idx;
  logic              last_k;

  assign last_k  = (k == ADDR_W'(NUM_NEURONS - 1));
  assign s_ready = (state == ST_IDLE);
  assign m_valid = (state == ST_OUT);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (s_valid) state_nxt = ST_EVAL;
      ST_EVAL: if (last_k)  state_nxt = ST_OUT;
      ST_OUT:  if (m_ready) state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  lut_fanin_gather #(.IN_W(IN_W), .FANIN(FANIN)) u_gather (
    .vec  (in_q),
    .conn (conn[k]),
    .idx  (idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      in_q   <= '0;
      m_data <= '0;
    end else begin
      if (state == ST_IDLE && s_valid) begin
        in_q <= s_data;
        k    <= '0;
      end
      if (state == ST_EVAL) begin
        m_data[k] <= tt[k][idx];
        k         <= k + ADDR_W'(1);
      end
    end
  end

`ifdef LUT_SCHED_CFG_EN
  logic cfg_ok;
  logic cfg_bad;

  always_comb begin
    cfg_ok  = cfg_we && (state != ST_EVAL) &&
              ({1'b0, cfg_addr} < (ADDR_W+1)'(NUM_NEURONS));
    cfg_bad = cfg_we && !cfg_ok;
  end

  // m_data is a register, so a write accepted in OUT only affects later vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        tt[n]   <= TT_INIT[n*TT_BITS +: TT_W];
        conn[n] <= conn_reset(n);
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
      if (cfg_ok) begin
        if (cfg_sel) conn[cfg_addr] <= cfg_wdata[CONN_W-1:0];
        else         tt[cfg_addr]   <= cfg_wdata[TT_W-1:0];
      end
    end
  end
`else
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_const
    assign tt[n]   = TT_INIT[n*TT_BITS +: TT_W];
    assign conn[n] = conn_reset(n);
  end

  assign cfg_err = 1'b0;

  logic cfg_unused;
  assign cfg_unused = ^{cfg_we, cfg_sel, cfg_addr, cfg_wdata};
`endif

endmodule

// File: tb/tb_lut_neuron_sched.sv
module tb_lut_neuron_sched;
  import lut_sched_pkg::*;

  localparam int IN_W = 32;
  localparam int NN   = 32;
  localparam int SEL  = 5;
  localparam int LAT  = NN;
  localparam int PER  = NN + 2;
`ifdef LUT_SCHED_CFG_EN
  localparam bit CFG_EN = 1'b1;
`else
  localparam bit CFG_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [NN-1:0]   m_data;
  logic            cfg_we;
  logic            cfg_sel;
  logic [4:0]      cfg_addr;
  logic [63:0]     cfg_wdata;
  logic            busy;
  logic            cfg_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int valid_cyc = 0;
  int prev_valid = 0;
  logic [NN-1:0] last_exp;
  logic [NN-1:0] sb [$];

  logic [63:0]       tt_m   [NN];
  logic [6*SEL-1:0]  conn_m [NN];

  lut_neuron_sched #(.IN_W(IN_W), .NUM_NEURONS(NN), .FANIN(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int n = 0; n < NN; n++) begin
      tt_m[n] = TT_INIT[n*64 +: 64];
      for (int j = 0; j < 6; j++) conn_m[n][j*SEL +: SEL] = SEL'((n + j) % IN_W);
    end
  endtask

  function automatic logic [NN-1:0] model(input logic [IN_W-1:0] v);
    logic [NN-1:0] r;
    logic [5:0] idx;
    for (int n = 0; n < NN; n++) begin
      for (int j = 0; j < 6; j++) idx[j] = v[conn_m[n][j*SEL +: SEL]];
      r[n] = tt_m[n][idx];
    end
    return r;
  endfunction

  task automatic send(input logic [IN_W-1:0] v);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = v;
    chk("s_ready_idle", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    s_valid = 1'b0;
    sb.push_back(model(v));
    chk("busy_eval", 64'(busy), 64'd1);
  endtask

  task automatic wait_out();
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 200 && !ok) begin
      @(posedge clk); #1;
      n++;
      if (m_valid === 1'b1) ok = 1'b1;
    end
    chk("m_valid_seen", 64'(ok), 64'd1);
    valid_cyc = cyc;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'(sb.size()), 64'd1);
      last_exp = '0;
    end else begin
      last_exp = sb.pop_front();
    end
    if (ok) begin
      chk("m_data", 64'(m_data), 64'(last_exp));
      chk("latency", 64'(valid_cyc - acc_cyc), 64'(LAT));
    end
  endtask

  task automatic run_vec(input logic [IN_W-1:0] v);
    send(v);
    wait_out();
    @(posedge clk); #1;
    chk("out_done", 64'(m_valid), 64'd0);
  endtask

  task automatic cfg_write(input logic sel, input logic [4:0] addr,
                           input logic [63:0] data, input bit in_eval);
    bit apply;
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    apply = CFG_EN && !in_eval;
    chk("cfg_err", 64'(cfg_err), 64'(CFG_EN && in_eval));
    if (apply) begin
      if (sel) conn_m[addr] = data[6*SEL-1:0];
      else     tt_m[addr]   = data;
    end
  endtask

  initial begin
    bit seen;
    logic [IN_W-1:0] v;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    init_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // default-table result first, then an identity configuration attempt
    run_vec(32'h1234_5678);
    for (int n = 0; n < NN; n++) begin
      cfg_write(1'b0, 5'(n), 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
      cfg_write(1'b1, 5'(n), 64'(n), 1'b0);
    end
    send(32'h0000_00F0);
    wait_out();
    if (CFG_EN) chk("identity", 64'(m_data), 64'h0000_00F0);
    @(posedge clk); #1;
    chk("out_done", 64'(m_valid), 64'd0);

    // streaming with m_ready high
    for (int i = 0; i < 100; i++) begin
      run_vec($urandom);
      if (i > 0) chk("period", 64'(valid_cyc - prev_valid), 64'(PER));
      prev_valid = valid_cyc;
    end

    // backpressure, plus a write while the result is held
    m_ready = 1'b0;
    send(32'hDEAD_BEEF);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_m_valid", 64'(m_valid), 64'd1);
      chk("bp_m_data", 64'(m_data), 64'(last_exp));
      chk("bp_s_ready", 64'(s_ready), 64'd0);
    end
    cfg_write(1'b0, 5'd4, ~tt_m[4], 1'b0);
    chk("out_write_hold", 64'(m_data), 64'(last_exp));
    @(negedge clk) m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(m_valid), 64'd0);
    chk("bp_release_ready", 64'(s_ready), 64'd1);
    run_vec(32'hFFFF_0000);
    run_vec(32'h0F0F_3C3C);

    // write during EVAL is rejected
    send(32'hA5A5_5A5A);
    cfg_write(1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    chk("cfg_err_pulse_end", 64'(cfg_err), 64'd0);
    wait_out();
    @(posedge clk); #1;
    run_vec(32'hA5A5_5A5A);

    // reset in the middle of EVAL (k = 10)
    v = $urandom;
    send(v);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_m_data", 64'(m_data), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    sb.delete();
    init_model();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0) seen = 1'b1;
    end
    chk("post_rst_no_valid", 64'(seen), 64'd0);
    chk("post_rst_m_data", 64'(m_data), 64'd0);
    run_vec(32'h0000_00F0);
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
